// File: rtl/pipebomb_pkg.sv
// rtl/pipebomb_pkg.sv - shared ITCH instruction types and ingress arbiter types
package pipebomb_pkg;

    typedef enum logic [3:0] {
        ITCH_NOP    = 4'h0,
        ITCH_ADD    = 4'h1,
        ITCH_EXEC   = 4'h2,
        ITCH_CANCEL = 4'h3,
        ITCH_DELETE = 4'h4
    } opcode_t;

    typedef struct packed {
        logic          valid;
        opcode_t       opcode;
        logic          last_in_bundle;
        logic [15:0]   payload;
    } inst_t;

    // Two-state ingress FSM, kept as plain constants for legacy tools.
    typedef logic [0:0] ingress_state_t;
    localparam ingress_state_t IDLE = 1'b0;
    localparam ingress_state_t LOCK = 1'b1;

    typedef struct packed {
        inst_t       d;
        logic [3:0]  chan;
    } out_beat_t;

    // Channel index visited at scan position off when the scan starts at base.
    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/pipebomb_mc_ingress_msg_fifo.sv
// rtl/pipebomb_mc_ingress_msg_fifo.sv - per-channel message FIFO with one-cycle write-to-read latency
module msg_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 32
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  T     din,
    output logic full,
    input  logic pop,
    output T     dout,
    output logic empty,
    output logic overflow
);
    localparam int AW = $clog2(DEPTH);

    T           mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, wr_vis_q, wr_vis_d;
    logic        do_push, do_pop;

    // Full uses the live write pointer; empty uses the delayed one so a new
    // entry only becomes poppable the cycle after it was written.
    always_comb begin
        full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty    = (wr_vis_q == rd_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        overflow = push && full;
        dout     = mem_q[rd_q[AW-1:0]];
        wr_d     = do_push ? wr_q + 1'b1 : wr_q;
        rd_d     = do_pop ? rd_q + 1'b1 : rd_q;
        wr_vis_d = wr_q;
    end

    // Pointer registers; reset flushes the queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q     <= '0;
            rd_q     <= '0;
            wr_vis_q <= '0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            wr_vis_q <= wr_vis_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pipebomb_mc_ingress.sv
// rtl/pipebomb_mc_ingress.sv - multi-channel bundle-granular round-robin ingress arbiter
module pipebomb_mc_ingress
    import pipebomb_pkg::*;
#(
    parameter int N_CHAN     = 4,
    parameter int FIFO_DEPTH = 32,
    parameter bit DROP_NOP   = 1'b1,
    parameter int TIMEOUT    = 255,
    localparam int CW        = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
    localparam int IW        = $bits(inst_t)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CHAN-1:0]    s_v,
    output logic [N_CHAN-1:0]    s_r,
    input  logic [N_CHAN*IW-1:0] s_inst,
    output logic                 m_v,
    input  logic                 m_r,
    output inst_t                m_d,
    output logic [CW-1:0]        m_chan,
    output logic                 bundle_abort,
    output logic [CW-1:0]        abort_chan,
    output logic [31:0]          nop_drop_cnt
);
    logic [N_CHAN-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
    inst_t             fifo_dout [N_CHAN];

    ingress_state_t state_q, state_d;
    logic [CW-1:0]  grant_q, grant_d, rr_q, rr_d, abort_chan_q, abort_chan_d;
    logic [15:0]    idle_cnt_q, idle_cnt_d;
    logic           out_v_q, out_v_d, abort_q, abort_d;
    out_beat_t      out_beat_q, out_beat_d;
    logic [31:0]    nop_cnt_q, nop_cnt_d;

    logic           scan_found, pop, head_empty;
    logic [CW-1:0]  scan_idx, next_rr;
    inst_t          head;

    assign s_r       = ~fifo_full & {N_CHAN{~rst}};
    assign fifo_push = s_v & s_r;

    for (genvar c = 0; c < N_CHAN; c++) begin : g_fifo
        msg_fifo #(.T(inst_t), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .rstn     (~rst),
            .push     (fifo_push[c]),
            .din      (s_inst[c*IW +: IW]),
            .full     (fifo_full[c]),
            .pop      (fifo_pop[c]),
            .dout     (fifo_dout[c]),
            .empty    (fifo_empty[c]),
            .overflow ()
        );
    end

    // First non-empty channel at or after the round-robin pointer.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = rr_q;
        for (int i = 0; i < N_CHAN; i++) begin
            if (!scan_found && !fifo_empty[CW'(rr_index(int'(rr_q), i, N_CHAN))]) begin
                scan_found = 1'b1;
                scan_idx   = CW'(rr_index(int'(rr_q), i, N_CHAN));
            end
        end
    end

    // Arbiter FSM, drop filter, output register, idle timeout and counters.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        idle_cnt_d   = idle_cnt_q;
        out_v_d      = out_v_q;
        out_beat_d   = out_beat_q;
        abort_d      = 1'b0;
        abort_chan_d = abort_chan_q;
        nop_cnt_d    = nop_cnt_q;
        pop          = 1'b0;
        fifo_pop     = '0;
        head         = fifo_dout[grant_q];
        head_empty   = fifo_empty[grant_q];
        next_rr      = (grant_q == CW'(N_CHAN - 1)) ? '0 : grant_q + 1'b1;

        if (out_v_q && m_r) out_v_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (scan_found) begin
                    grant_d    = scan_idx;
                    state_d    = LOCK;
                    idle_cnt_d = '0;
                end
            end
            LOCK: begin
                if (!head_empty && (!out_v_q || m_r)) begin
                    pop               = 1'b1;
                    fifo_pop[grant_q] = 1'b1;
                    idle_cnt_d        = '0;
                    if (DROP_NOP && !head.last_in_bundle &&
                        (head.opcode == ITCH_NOP || !head.valid)) begin
                        if (nop_cnt_q != 32'hFFFF_FFFF) nop_cnt_d = nop_cnt_q + 32'd1;
                    end else begin
                        out_v_d         = 1'b1;
                        out_beat_d.d    = head;
                        out_beat_d.chan = 4'(grant_q);
                    end
                    if (head.last_in_bundle) begin
                        state_d = IDLE;
                        rr_d    = next_rr;
                    end
                end else if (head_empty) begin
                    idle_cnt_d = (idle_cnt_q == 16'hFFFF) ? idle_cnt_q : idle_cnt_q + 16'd1;
                    if ({1'b0, idle_cnt_q} + 17'd1 >= 17'(TIMEOUT)) begin
                        abort_d      = 1'b1;
                        abort_chan_d = grant_q;
                        state_d      = IDLE;
                        rr_d         = next_rr;
                        idle_cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight beat without an abort pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_q         <= '0;
            idle_cnt_q   <= '0;
            out_v_q      <= 1'b0;
            out_beat_q   <= '0;
            abort_q      <= 1'b0;
            abort_chan_q <= '0;
            nop_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            idle_cnt_q   <= idle_cnt_d;
            out_v_q      <= out_v_d;
            out_beat_q   <= out_beat_d;
            abort_q      <= abort_d;
            abort_chan_q <= abort_chan_d;
            nop_cnt_q    <= nop_cnt_d;
        end
    end

    assign m_v          = out_v_q;
    assign m_d          = out_beat_q.d;
    assign m_chan       = CW'(out_beat_q.chan);
    assign bundle_abort = abort_q;
    assign abort_chan   = abort_chan_q;
    assign nop_drop_cnt = nop_cnt_q;

endmodule

// File: tb/tb_pipebomb_mc_ingress.sv
// tb/tb_pipebomb_mc_ingress.sv - directed self-checking bench for pipebomb_mc_ingress
module tb_pipebomb_mc_ingress;
    import pipebomb_pkg::*;

    localparam int NC = 4;
    localparam int W  = $bits(inst_t);

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   s_v, s_r;
    inst_t           s_arr [NC];
    logic [NC*W-1:0] s_inst;
    logic            m_v, m_r;
    inst_t           m_d;
    logic [1:0]      m_chan, abort_chan;
    logic            bundle_abort;
    logic [31:0]     nop_drop_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [1:0] chan;
        inst_t      d;
    } rec_t;
    rec_t q[$];

    assign s_inst = {s_arr[3], s_arr[2], s_arr[1], s_arr[0]};

    pipebomb_mc_ingress #(
        .N_CHAN(NC), .FIFO_DEPTH(32), .DROP_NOP(1'b1), .TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_v          (s_v),
        .s_r          (s_r),
        .s_inst       (s_inst),
        .m_v          (m_v),
        .m_r          (m_r),
        .m_d          (m_d),
        .m_chan       (m_chan),
        .bundle_abort (bundle_abort),
        .abort_chan   (abort_chan),
        .nop_drop_cnt (nop_drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every beat that will be taken at the coming edge.
    always @(negedge clk) begin
        if (!rst && m_v && m_r) q.push_back('{cyc, m_chan, m_d});
    end

    function automatic inst_t mk(input opcode_t op, input logic v, input logic l, input logic [15:0] p);
        inst_t r;
        r.valid = v; r.opcode = op; r.last_in_bundle = l; r.payload = p;
        return r;
    endfunction

    function automatic rec_t get(input int i);
        rec_t r;
        r.cyc = -1; r.chan = 2'b11; r.d = '0;
        if (i < q.size()) r = q[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while (q.size() < n && k < budget) begin
            tick();
            k++;
        end
        repeat (5) tick();
        check(tag, 64'(q.size()), 64'(n));
    endtask

    initial begin
        int t0, n, err, ab_cyc, k;
        logic stable;
        inst_t exp_d;

        rst = 1'b1; m_r = 1'b1; s_v = '0;
        for (int c = 0; c < NC; c++) s_arr[c] = '0;
        tick(); tick();
        check("rst_m_v", 64'(m_v), 64'd0);
        check("rst_m_d", 64'(m_d), 64'd0);
        check("rst_m_chan", 64'(m_chan), 64'd0);
        check("rst_abort", 64'(bundle_abort), 64'd0);
        check("rst_abort_chan", 64'(abort_chan), 64'd0);
        check("rst_nop_cnt", 64'(nop_drop_cnt), 64'd0);
        check("rst_s_r", 64'(s_r), 64'd0);
        rst = 1'b0;
        tick();
        check("s_r_after_rst", 64'(s_r), 64'hF);

        // Two-channel interleave: A on ch0 (3 beats), B on ch1 (2 beats).
        q.delete();
        s_v = 4'b0011;
        s_arr[0] = mk(ITCH_ADD, 1, 0, 16'hA0); s_arr[1] = mk(ITCH_ADD, 1, 0, 16'hB0);
        tick(); t0 = cyc;
        s_arr[0] = mk(ITCH_ADD, 1, 0, 16'hA1); s_arr[1] = mk(ITCH_ADD, 1, 1, 16'hB1);
        tick();
        s_v = 4'b0001; s_arr[0] = mk(ITCH_ADD, 1, 1, 16'hA2);
        tick();
        s_v = '0;
        wait_beats(5, 40, "ilv_count");
        err = 0;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: exp_d = mk(ITCH_ADD, 1, 0, 16'hA0);
                1: exp_d = mk(ITCH_ADD, 1, 0, 16'hA1);
                2: exp_d = mk(ITCH_ADD, 1, 1, 16'hA2);
                3: exp_d = mk(ITCH_ADD, 1, 0, 16'hB0);
                default: exp_d = mk(ITCH_ADD, 1, 1, 16'hB1);
            endcase
            if (get(i).d !== exp_d || get(i).chan !== ((i < 3) ? 2'd0 : 2'd1)) err++;
        end
        check("ilv_order", 64'(err), 64'd0);
        check("ilv_latency", 64'(get(0).cyc - t0), 64'd3);
        check("ilv_throughput", 64'(get(2).cyc - get(0).cyc), 64'd2);
        check("ilv_bubble", 64'(get(3).cyc - get(2).cyc), 64'd2);

        // NOP filtering on ch0.
        q.delete();
        s_v = 4'b0001;
        s_arr[0] = mk(ITCH_ADD, 1, 0, 16'h11); tick();
        s_arr[0] = mk(ITCH_NOP, 1, 0, 16'h12); tick();
        s_arr[0] = mk(ITCH_ADD, 0, 0, 16'h13); tick();
        s_arr[0] = mk(ITCH_NOP, 1, 1, 16'h14); tick();
        s_v = '0;
        wait_beats(2, 40, "nop_count");
        check("nop_beat0", 64'(get(0).d), 64'(mk(ITCH_ADD, 1, 0, 16'h11)));
        check("nop_beat1", 64'(get(1).d), 64'(mk(ITCH_NOP, 1, 1, 16'h14)));
        check("nop_drop_cnt", 64'(nop_drop_cnt), 64'd2);

        // Backpressure on ch1: output stalled, FIFO fills.
        q.delete();
        m_r = 1'b0;
        n = 0;
        while (n < 40 && s_r[1]) begin
            s_v[1] = 1'b1; s_arr[1] = mk(ITCH_ADD, 1, 0, 16'(16'h200 + n));
            tick();
            n++;
        end
        s_v = '0;
        check("bp_accept", 64'(n), 64'd33);
        check("bp_s_r_low", 64'(s_r[1]), 64'd0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!m_v || m_d !== mk(ITCH_ADD, 1, 0, 16'h200)) stable = 1'b0;
        end
        check("bp_hold", 64'(stable), 64'd1);
        m_r = 1'b1;
        tick();
        check("bp_s_r_rise", 64'(s_r[1]), 64'd1);
        s_v[1] = 1'b1; s_arr[1] = mk(ITCH_ADD, 1, 1, 16'h221);
        tick();
        s_v = '0;
        wait_beats(34, 100, "bp_count");
        err = 0;
        for (int i = 0; i < 34; i++) begin
            if (get(i).chan !== 2'd1 ||
                get(i).d !== mk(ITCH_ADD, 1, (i == 33), 16'(16'h200 + i))) err++;
        end
        check("bp_sequence", 64'(err), 64'd0);

        // Timeout: ch2 stalls mid-bundle, ch3 bundle pending.
        q.delete();
        s_v = 4'b1100;
        s_arr[2] = mk(ITCH_ADD, 1, 0, 16'h300); s_arr[3] = mk(ITCH_ADD, 1, 1, 16'h400);
        tick();
        s_v = '0;
        k = 0;
        while (!bundle_abort && k < 40) begin
            tick();
            k++;
        end
        ab_cyc = cyc;
        check("to_seen", 64'(bundle_abort), 64'd1);
        check("to_chan", 64'(abort_chan), 64'd2);
        check("to_delay", 64'(ab_cyc - get(0).cyc), 64'd4);
        tick();
        check("to_pulse_1cyc", 64'(bundle_abort), 64'd0);
        s_v[2] = 1'b1; s_arr[2] = mk(ITCH_ADD, 1, 1, 16'h301);
        tick();
        s_v = '0;
        wait_beats(3, 40, "to_count");
        check("to_first", 64'({get(0).chan, get(0).d}), 64'({2'd2, mk(ITCH_ADD, 1, 0, 16'h300)}));
        check("to_next_ch3", 64'({get(1).chan, get(1).d}), 64'({2'd3, mk(ITCH_ADD, 1, 1, 16'h400)}));
        check("to_late_beat", 64'({get(2).chan, get(2).d}), 64'({2'd2, mk(ITCH_ADD, 1, 1, 16'h301)}));

        // Mid-bundle reset.
        q.delete();
        m_r = 1'b0;
        s_v = 4'b0001;
        s_arr[0] = mk(ITCH_ADD, 1, 0, 16'h600); tick();
        s_arr[0] = mk(ITCH_ADD, 1, 0, 16'h601); tick();
        s_v = '0;
        k = 0;
        while (!m_v && k < 20) begin
            tick();
            k++;
        end
        check("mrst_pre_m_v", 64'(m_v), 64'd1);
        rst = 1'b1;
        #1;
        check("mrst_m_v_drop", 64'(m_v), 64'd0);
        check("mrst_s_r", 64'(s_r), 64'd0);
        tick();
        rst = 1'b0; m_r = 1'b1;
        repeat (20) tick();
        check("mrst_no_stale", 64'(q.size()), 64'd0);
        check("mrst_m_v_idle", 64'(m_v), 64'd0);
        check("mrst_nop_cnt", 64'(nop_drop_cnt), 64'd0);

        // Fairness: every channel sends 1-beat bundles.
        q.delete();
        for (int r = 0; r < 3; r++) begin
            s_v = 4'hF;
            for (int c = 0; c < NC; c++) s_arr[c] = mk(ITCH_ADD, 1, 1, 16'(16'h500 + r * 16 + c));
            tick();
        end
        s_v = '0;
        wait_beats(12, 100, "fair_count");
        err = 0;
        for (int i = 0; i < 12; i++) begin
            if (get(i).chan !== 2'(i % 4) ||
                get(i).d !== mk(ITCH_ADD, 1, 1, 16'(16'h500 + (i / 4) * 16 + i % 4))) err++;
        end
        check("fair_order", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
